// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults for the byte demultiplexer and its lane FIFOs.
//   DATA_W_DEF     - default byte width
//   FIFO_DEPTH_DEF - default entries per lane FIFO (power of two, >= 2)
//   LANE0 / LANE1  - lane index values carried by lane_sel
package demux_pkg;
  localparam int   DATA_W_DEF     = 8;
  localparam int   FIFO_DEPTH_DEF = 4;
  localparam logic LANE0          = 1'b0;
  localparam logic LANE1          = 1'b1;
endpackage

// File: rtl/fifo_lane.sv
// fifo_lane: synchronous first-word-fall-through FIFO for one demux lane.
//   clk, Reset  - rising-edge clock, synchronous active-high reset
//   push, pop   - write data_in / remove head (pop on empty is ignored)
//   data_in     - byte to enqueue
//   data_out    - head byte, forced to 0 while empty
//   not_empty   - at least one entry held
//   full        - DEPTH entries held
//   drop        - this cycle's push is rejected (full, no pop)
module fifo_lane
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              not_empty,
  output logic              full,
  output logic              drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              pop_ok, push_ok;

  // Status comes from the registered occupancy only.
  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));

  // A pop frees the slot the same cycle, so a full lane can still accept.
  assign pop_ok  = pop & not_empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  assign data_out = not_empty ? mem[rd_ptr] : '0;

  // Storage carries no reset; data_out masks stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/demux_memoria_8bits.sv
// demux_memoria_8bits: splits an interleaved byte stream into two FWFT lanes.
// Optional feature macro: DEMUX_OVF_CNT_EN adds the ovf_cnt dropped-byte counter.
//   clk, Reset      - rising-edge clock, synchronous active-high reset
//   valid_in        - data_in carries a byte this cycle
//   data_in         - byte stream from upstream 2:1 mux
//   pop0 / pop1     - consumer takes head of lane 0 / lane 1
//   out0 / out1     - head byte of each lane (0 when empty)
//   valid0 / valid1 - lane non-empty
//   full0 / full1   - lane holds FIFO_DEPTH entries
//   lane_sel        - lane receiving the next valid byte
//   ovf_cnt         - saturating dropped-byte count (DEMUX_OVF_CNT_EN only)
module demux_memoria_8bits
  import demux_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop0,
  input  logic              pop1,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              valid0,
  output logic              valid1,
  output logic              full0,
  output logic              full1,
  output logic              lane_sel
`ifdef DEMUX_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);
  logic push0, push1, drop0, drop1;

  assign push0 = valid_in & (lane_sel == LANE0);
  assign push1 = valid_in & (lane_sel == LANE1);

  // lane_sel toggles on every valid byte, dropped or not, so the two lanes
  // stay aligned with the upstream interleave.
  always_ff @(posedge clk) begin
    if (Reset)         lane_sel <= LANE0;
    else if (valid_in) lane_sel <= ~lane_sel;
  end

  fifo_lane #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_lane0 (
    .clk(clk), .Reset(Reset), .push(push0), .pop(pop0), .data_in(data_in),
    .data_out(out0), .not_empty(valid0), .full(full0), .drop(drop0)
  );

  fifo_lane #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_lane1 (
    .clk(clk), .Reset(Reset), .push(push1), .pop(pop1), .data_in(data_in),
    .data_out(out1), .not_empty(valid1), .full(full1), .drop(drop1)
  );

`ifdef DEMUX_OVF_CNT_EN
  // Only one lane is pushed per cycle, so at most one drop per cycle.
  always_ff @(posedge clk) begin
    if (Reset)                                     ovf_cnt <= '0;
    else if ((drop0 | drop1) && ovf_cnt != 8'hFF)  ovf_cnt <= ovf_cnt + 8'd1;
  end
`else
  logic drops_unused;
  assign drops_unused = drop0 | drop1;
`endif
endmodule

// File: tb/tb_demux_memoria_8bits.sv
// Scoreboard bench: the driver updates a queue-based lane model at every edge;
// an independent monitor compares DUT outputs against it on each falling edge.
module tb_demux_memoria_8bits;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          pop0 = 1'b0, pop1 = 1'b0;
  logic [DW-1:0] out0, out1;
  logic          valid0, valid1, full0, full1, lane_sel;
`ifdef DEMUX_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  always #5 clk = ~clk;

  demux_memoria_8bits #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .Reset(Reset), .valid_in(valid_in), .data_in(data_in),
    .pop0(pop0), .pop1(pop1), .out0(out0), .out1(out1),
    .valid0(valid0), .valid1(valid1), .full0(full0), .full1(full1),
    .lane_sel(lane_sel)
`ifdef DEMUX_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  // Reference model: two byte queues, the next-lane bit, and the drop count.
  logic [DW-1:0] q0[$], q1[$];
  bit            m_sel = 1'b0;
  int            m_ovf = 0;
  bit            mon_en = 1'b0;

  int tests = 0, fails = 0;

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_edge(bit r, bit v, logic [DW-1:0] d, bit p0, bit p1);
    if (r) begin
      q0.delete(); q1.delete(); m_sel = 1'b0; m_ovf = 0; mon_en = 1'b1;
      return;
    end
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    if (v) begin
      if (m_sel == 1'b0) begin
        if (q0.size() < DEPTH) q0.push_back(d); else if (m_ovf < 255) m_ovf++;
      end else begin
        if (q1.size() < DEPTH) q1.push_back(d); else if (m_ovf < 255) m_ovf++;
      end
      m_sel = ~m_sel;
    end
  endfunction

  // Drive one cycle, let the edge happen, advance the model, settle.
  task automatic cyc(bit r, bit v, logic [DW-1:0] d, bit p0, bit p1);
    Reset = r; valid_in = v; data_in = d; pop0 = p0; pop1 = p1;
    @(posedge clk);
    model_edge(r, v, d, p0, p1);
    #1;
  endtask

  task automatic idle(); cyc(0, 0, 8'h00, 0, 0); endtask
  task automatic rst();  cyc(1, 0, 8'h00, 0, 0); endtask
  task automatic push(logic [DW-1:0] d, bit p0 = 0, bit p1 = 0); cyc(0, 1, d, p0, p1); endtask

  // Monitor: DUT outputs versus model state each falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_valid0", int'(valid0), int'(q0.size() > 0));
      chk("mon_valid1", int'(valid1), int'(q1.size() > 0));
      chk("mon_out0",   int'(out0),   q0.size() > 0 ? int'(q0[0]) : 0);
      chk("mon_out1",   int'(out1),   q1.size() > 0 ? int'(q1[0]) : 0);
      chk("mon_full0",  int'(full0),  int'(q0.size() == DEPTH));
      chk("mon_full1",  int'(full1),  int'(q1.size() == DEPTH));
      chk("mon_lane_sel", int'(lane_sel), int'(m_sel));
`ifdef DEMUX_OVF_CNT_EN
      chk("mon_ovf_cnt", int'(ovf_cnt), m_ovf);
`endif
    end
  end

  initial begin
    rst(); rst();
    chk("rst_valid0", int'(valid0), 0);
    chk("rst_valid1", int'(valid1), 0);
    chk("rst_full0", int'(full0), 0);
    chk("rst_lane_sel", int'(lane_sel), 0);
    chk("rst_out0", int'(out0), 0);

    // Basic interleave
    push(8'h00); push(8'h03); push(8'h01); push(8'h04);
    chk("il_out0", int'(out0), 8'h00);
    chk("il_out1", int'(out1), 8'h03);
    chk("il_lane_sel", int'(lane_sel), 0);

    // Overflow at depth 4
    rst();
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
    chk("ovf_full0", int'(full0), 1);
    chk("ovf_full1", int'(full1), 1);
    chk("ovf_out0", int'(out0), 8'h10);
    chk("ovf_out1", int'(out1), 8'h11);
`ifdef DEMUX_OVF_CNT_EN
    chk("ovf_cnt2", int'(ovf_cnt), 2);
`endif

    // Push into full lane0 with simultaneous pop
    push(8'h20, 1, 0);
    chk("fp_out0", int'(out0), 8'h12);
    chk("fp_full0", int'(full0), 1);
`ifdef DEMUX_OVF_CNT_EN
    chk("fp_ovf_cnt", int'(ovf_cnt), 2);
`endif
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1, 0);
    chk("fp_tail", int'(out0), 8'h20);

    // Underflow-safe pops on empty lane1
    rst();
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0, 1);
    chk("uf_valid1", int'(valid1), 0);
    chk("uf_out1", int'(out1), 0);
    push(8'h01); push(8'hAA);
    chk("uf_out1_aa", int'(out1), 8'hAA);

    // Reset mid-stream
    rst();
    push(8'h31); push(8'h32); push(8'h33); idle(); rst();
    chk("mr_valid0", int'(valid0), 0);
    chk("mr_valid1", int'(valid1), 0);
    chk("mr_lane_sel", int'(lane_sel), 0);
    push(8'h55);
    chk("mr_out0", int'(out0), 8'h55);

    // valid_in gaps
    rst();
    cyc(0, 1, 8'h01, 0, 0); cyc(0, 0, 8'hFF, 0, 0);
    cyc(0, 1, 8'h02, 0, 0); cyc(0, 0, 8'hFF, 0, 0);
    chk("gap_out0", int'(out0), 8'h01);
    chk("gap_out1", int'(out1), 8'h02);
    chk("gap_lane_sel", int'(lane_sel), 0);

    // Drop counter saturation
    rst();
    for (int i = 0; i < 600; i++) push(8'(i));
`ifdef DEMUX_OVF_CNT_EN
    chk("sat_ovf_cnt", int'(ovf_cnt), 255);
`endif
    chk("sat_full0", int'(full0), 1);

    // Random traffic
    rst();
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
